// File: rtl/gen_scheduler.sv
// Generation sequencer and board-RAM arbiter for the Game of Life core.
// Latency: grants/mem_* combinational; eng_start 1 cycle after the COMPUTE decision; rvalid 1 cycle after a read grant.
// Backpressure: fixed priority display > editor > engine; editor is stalled (no grant) while a generation is in flight.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   run, step, vblank             user run level, single-step pulse, vertical blanking level
//   disp_* / edit_* / eng_*       requester ports (req, we, addr, wdata) and their gnt/rvalid
//   mem_addr/mem_we/mem_wdata     single-port board RAM; mem_addr = {bank, cell-word address}
//   eng_start, eng_done           life engine handshake (one-cycle pulses)
//   buf_sel, gen_count, busy      displayed bank, completed generations, generation in flight
module gen_scheduler #(
    parameter int LOG_WAIT_COUNT = 24,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step,
    input  logic                  vblank,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    input  logic                  edit_req,
    input  logic                  edit_we,
    input  logic [ADDR_WIDTH-1:0] edit_addr,
    input  logic [DATA_WIDTH-1:0] edit_wdata,
    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    output logic                  disp_gnt,
    output logic                  edit_gnt,
    output logic                  eng_gnt,
    output logic                  disp_rvalid,
    output logic                  edit_rvalid,
    output logic                  eng_rvalid,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  eng_start,
    input  logic                  eng_done,
    output logic                  buf_sel,
    output logic [15:0]           gen_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_WAIT  = 2'd1,
        COMPUTE   = 2'd2,
        SWAP_WAIT = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [LOG_WAIT_COUNT-1:0] timer;
    logic [LOG_WAIT_COUNT-1:0] timer_nxt;
    logic                      swap;
    logic                      edit_allow;

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        swap      = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                // step takes precedence over run
                if (step) begin
                    state_nxt = COMPUTE;
                end else if (run) begin
                    state_nxt = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                if (!run) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (&timer) begin
                    // all-ones reached: exactly 2^LOG_WAIT_COUNT cycles spent here
                    state_nxt = COMPUTE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + LOG_WAIT_COUNT'(1);
                end
            end
            COMPUTE: begin
                // run/step have no effect; a started generation always finishes
                if (eng_done) begin
                    state_nxt = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                // bank swap only inside blanking so a frame never shows a mix of banks
                if (vblank) begin
                    swap      = 1'b1;
                    timer_nxt = '0;
                    state_nxt = run ? RUN_WAIT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            buf_sel   <= 1'b0;
            gen_count <= 16'd0;
            eng_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            // pulse only on entry into COMPUTE
            eng_start <= (state_nxt == COMPUTE) && (state != COMPUTE);
            if (swap) begin
                buf_sel   <= ~buf_sel;
                gen_count <= gen_count + 16'd1;
            end
        end
    end

    assign busy = (state == COMPUTE) || (state == SWAP_WAIT);

    // ------------------------------------------------------------------
    // RAM arbitration
    // ------------------------------------------------------------------
    // The editor is held off while the engine owns the generation, so an edit
    // cannot land in the display bank just before that bank is swapped out.
    assign edit_allow = (state == IDLE) || (state == RUN_WAIT);

    always_comb begin
        disp_gnt  = 1'b0;
        edit_gnt  = 1'b0;
        eng_gnt   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_req) begin
            disp_gnt = 1'b1;
            mem_addr = {buf_sel, disp_addr};
        end else if (edit_req && edit_allow) begin
            edit_gnt  = 1'b1;
            mem_addr  = {buf_sel, edit_addr};
            mem_we    = edit_we;
            mem_wdata = edit_wdata;
        end else if (eng_req) begin
            eng_gnt   = 1'b1;
            // engine reads the displayed bank and writes the hidden one
            mem_addr  = {(eng_we ? ~buf_sel : buf_sel), eng_addr};
            mem_we    = eng_we;
            mem_wdata = eng_wdata;
        end
    end

    // RAM read latency is one cycle; tag the returning data with its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_rvalid <= 1'b0;
            edit_rvalid <= 1'b0;
            eng_rvalid  <= 1'b0;
        end else begin
            disp_rvalid <= disp_gnt;
            edit_rvalid <= edit_gnt & ~edit_we;
            eng_rvalid  <= eng_gnt & ~eng_we;
        end
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with a 4-cycle free-run period.
// Inputs driven 1 time unit after the rising edge; outputs sampled after settling.
// Each check compares against hand-computed expected values.
module tb_gen_scheduler;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, step, vblank;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          edit_req, edit_we;
    logic [AW-1:0] edit_addr;
    logic [DW-1:0] edit_wdata;
    logic          eng_req, eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic          disp_gnt, edit_gnt, eng_gnt;
    logic          disp_rvalid, edit_rvalid, eng_rvalid;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          eng_start, eng_done;
    logic          buf_sel;
    logic [15:0]   gen_count;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    gen_scheduler #(
        .LOG_WAIT_COUNT(2),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .vblank     (vblank),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .edit_req   (edit_req),
        .edit_we    (edit_we),
        .edit_addr  (edit_addr),
        .edit_wdata (edit_wdata),
        .eng_req    (eng_req),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .disp_gnt   (disp_gnt),
        .edit_gnt   (edit_gnt),
        .eng_gnt    (eng_gnt),
        .disp_rvalid(disp_rvalid),
        .edit_rvalid(edit_rvalid),
        .eng_rvalid (eng_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .buf_sel    (buf_sel),
        .gen_count  (gen_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_bufsel"},  32'(buf_sel), 0);
        check({tag, "_gen"},     32'(gen_count), 0);
        check({tag, "_start"},   32'(eng_start), 0);
        check({tag, "_gnts"},    32'({disp_gnt, edit_gnt, eng_gnt}), 0);
        check({tag, "_rvalids"}, 32'({disp_rvalid, edit_rvalid, eng_rvalid}), 0);
        check({tag, "_memwe"},   32'(mem_we), 0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; vblank = 1'b0; eng_done = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        edit_req = 1'b0; edit_we = 1'b0; edit_addr = '0; edit_wdata = '0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;

        // ---------------- reset state ----------------
        #12;
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- free-run: start 4 cycles after RUN_WAIT entry ----------------
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("run_wait_start_%0d", i), 32'(eng_start), 0);
        end
        tick();
        check("run_start_pulse", 32'(eng_start), 1);
        check("run_busy", 32'(busy), 1);
        tick();
        check("run_start_one_cycle", 32'(eng_start), 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        // swap must wait for vblank
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) begin
                check($sformatf("swapwait_busy_%0d", i), 32'(busy), 1);
                check($sformatf("swapwait_bufsel_%0d", i), 32'(buf_sel), 0);
                check($sformatf("swapwait_gen_%0d", i), 32'(gen_count), 0);
            end
        end
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("swap1_bufsel", 32'(buf_sel), 1);
        check("swap1_gen", 32'(gen_count), 1);
        check("swap1_busy", 32'(busy), 0);
        run = 1'b0;
        tick();
        check("run_off_idle", 32'(busy), 0);

        // ---------------- single step, second step ignored ----------------
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_start", 32'(eng_start), 1);
        check("step_busy", 32'(busy), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step2_no_start", 32'(eng_start), 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("step_gen", 32'(gen_count), 2);
        check("step_bufsel", 32'(buf_sel), 0);
        check("step_idle", 32'(busy), 0);
        tick();
        check("step_dropped_busy", 32'(busy), 0);
        check("step_dropped_start", 32'(eng_start), 0);

        // ---------------- arbitration in IDLE (buf_sel 0) ----------------
        disp_req = 1'b1; disp_addr = 12'h123;
        edit_req = 1'b1; edit_we = 1'b0; edit_addr = 12'h0AB; edit_wdata = 16'hBEEF;
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 12'h005; eng_wdata = 16'h1234;
        #1;
        check("arb_all_gnts", 32'({disp_gnt, edit_gnt, eng_gnt}), 32'b100);
        check("arb_disp_addr", 32'(mem_addr), 32'h0123);
        check("arb_disp_we", 32'(mem_we), 0);
        tick();
        check("disp_rvalid", 32'(disp_rvalid), 1);
        disp_req = 1'b0; edit_we = 1'b1;
        #1;
        check("arb_edit_gnts", 32'({disp_gnt, edit_gnt, eng_gnt}), 32'b010);
        check("edit_wr_addr", 32'(mem_addr), 32'h00AB);
        check("edit_wr_we", 32'(mem_we), 1);
        check("edit_wr_data", 32'(mem_wdata), 32'hBEEF);
        tick();
        check("edit_wr_no_rvalid", 32'({disp_rvalid, edit_rvalid}), 0);
        edit_we = 1'b0;
        tick();
        check("edit_rd_rvalid", 32'(edit_rvalid), 1);

        // ---------------- arbitration in COMPUTE ----------------
        step = 1'b1;
        tick();
        step = 1'b0;
        check("cmp_gnts", 32'({disp_gnt, edit_gnt, eng_gnt}), 32'b001);
        check("eng_wr_addr", 32'(mem_addr), 32'h1005);
        check("eng_wr_we", 32'(mem_we), 1);
        check("eng_wr_data", 32'(mem_wdata), 32'h1234);
        eng_we = 1'b0;
        #1;
        check("eng_rd_addr", 32'(mem_addr), 32'h0005);
        check("eng_rd_we", 32'(mem_we), 0);
        tick();
        check("eng_rvalid", 32'(eng_rvalid), 1);
        check("edit_stalled_rvalid", 32'(edit_rvalid), 0);
        eng_req = 1'b0; edit_req = 1'b0;
        tick();
        check("eng_rvalid_drop", 32'(eng_rvalid), 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("swap3_bufsel", 32'(buf_sel), 1);
        check("swap3_gen", 32'(gen_count), 3);

        // bank mapping with buf_sel 1
        eng_req = 1'b1; eng_we = 1'b1;
        #1;
        check("bank1_eng_wr_addr", 32'(mem_addr), 32'h0005);
        eng_we = 1'b0;
        #1;
        check("bank1_eng_rd_addr", 32'(mem_addr), 32'h1005);
        eng_req = 1'b0;
        tick();

        // ---------------- gen_count wrap ----------------
        force dut.gen_count = 16'hFFFF;
        #1;
        release dut.gen_count;
        #1;
        check("gen_preload", 32'(gen_count), 32'hFFFF);
        step = 1'b1;
        tick();
        step = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("gen_wrap", 32'(gen_count), 0);
        check("wrap_bufsel", 32'(buf_sel), 0);

        // ---------------- reset during COMPUTE ----------------
        buf_sel_setup: begin
            step = 1'b1;
            tick();
            step = 1'b0;
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            vblank = 1'b1;
            tick();
            vblank = 1'b0;
        end
        check("pre_rst_bufsel", 32'(buf_sel), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("post_rst_done_ignored", 32'(busy), 0);
        check("post_rst_gen", 32'(gen_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
